top_handshakes: RTL and testbench
=================================

// Module: top_handshakes
//
// PURPOSE
// Valid/ready streaming demo path: master -> skid buffer -> slave.
// - Master: fetches words from an external combinational memory by address and
//   offers them on a valid/ready interface.
// - Skid buffer: fully registers m_ready and absorbs one word when the slave
//   stalls.
// - Slave: accepts words and registers the last accepted one on s_data_out.
// Sits at the top of the handshake test path; the memory lives outside.
//
// PARAMETERS
// WIDTH       8   data word width (master, buffer, slave)
// ADDR_WIDTH  8   memory address width; addr wraps modulo 2**ADDR_WIDTH
//
// PORTS
// clk         in   1           single clock; all state on rising edge
// rst         in   1           reset, synchronous, active-high
// valid_en    in   1           master may offer a new word this cycle
// ready_en    in   1           slave willing to accept (registered into s_ready)
// m_valid     out  1           master -> buffer valid
// m_ready     out  1           buffer -> master ready (= buffer empty)
// s_valid     out  1           buffer -> slave valid
// s_ready     out  1           slave -> buffer ready
// m_data_in   in   WIDTH       memory read data, combinational from addr
// m_data_out  out  WIDTH       master output word
// s_data_in   out  WIDTH       word presented to slave
// s_data_out  out  WIDTH       last word accepted by slave
// addr        out  ADDR_WIDTH  next memory address to fetch
//
// BEHAVIOUR
// Interface:
// - One clock; reset is synchronous and active-high.
// - Reset state: addr=0, m_valid=0, m_data_out=0, buffer empty (full=0, buf=0),
//   s_ready=0, s_data_out=0.
// - Hence m_ready=1, s_valid=0, s_data_in=0 while in reset.
// Master:
// - m_take = m_valid & m_ready. Master may load when !m_valid | m_ready.
// - Load: if valid_en and master may load, then
//   m_data_out<=m_data_in (mem[addr]), m_valid<=1, addr<=addr+1 (wraps).
// - Idle: if master may load and !valid_en, then m_valid<=0. m_data_out and
//   addr hold.
// - Stall: m_valid & !m_ready -> m_valid, m_data_out and addr hold (no data
//   change while valid).
// Skid buffer:
// - m_ready = !full. It is a register output, so there is no combinational
//   path from s_ready.
// - s_valid   = full | m_valid
// - s_data_in = full ? buf : m_data_out   (passthrough when empty)
// - Capture: m_take & !s_ready (buffer empty) -> buf<=m_data_out, full<=1.
// - Drain: full & s_ready -> full<=0. m_ready rises the next cycle.
// - full & !s_ready: hold. Master is stalled, so at most 2 words are in flight.
// - Never drops or duplicates a word; output order equals fetch order.
// Slave:
// - s_ready <= ready_en (one-cycle registered).
// - s_take = s_valid & s_ready -> s_data_out<=s_data_in. Otherwise hold.
// Boundary cases:
// - Simultaneous drain and master offer: buffer word goes first. The master
//   word waits (m_ready=0 that cycle) and passes through or captures later.
// - valid_en dropping mid-stall: the pending m_valid word is still delivered.
//   valid_en only gates new loads.
// - addr 255->0 wrap is seamless.
// - rst asserted mid-operation discards in-flight words. Fetching restarts
//   at addr 0.
//
// TESTING (memory preloaded mem[i]=i)
// 1. Streaming: rst 1 cycle, then valid_en=1, ready_en=1 continuously
//    -> s_data_out = 0,1,2,3,... one per cycle after the fill latency, no gaps.
// 2. Slave stall: while streaming, ready_en=0 for 4 cycles
//    -> buffer captures exactly one word, m_ready=0, addr frozen.
//    On ready_en=1 the sequence resumes in order with no loss or duplicate.
// 3. Master idle: valid_en=0 with ready_en=1
//    -> m_valid and s_valid drop after the pending word.
//    s_data_out holds the last value; addr unchanged.
// 4. Stall then idle: ready_en=0, valid_en=0 together
//    -> held word(s) delivered once ready_en=1; then s_valid=0.
// 5. Wrap: >=258 continuous transfers
//    -> s_data_out ...,254,255,0,1; addr wraps to 0.
// 6. Reset mid-stall (buffer full), plus random valid_en/ready_en
//    -> all outputs return to reset values.
//    Scoreboard: each s_take value = previous+1 mod 256.

Source files
------------

// File: rtl/top_handshakes.sv
// Valid/ready demo path: memory-fetching master -> skid buffer -> registering slave.
// The skid buffer registers m_ready so the slave's ready never reaches the master combinationally.
module top_handshakes #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_en,
  input  logic                  ready_en,
  output logic                  m_valid,
  output logic                  m_ready,
  output logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      m_data_in,
  output logic [WIDTH-1:0]      m_data_out,
  output logic [WIDTH-1:0]      s_data_in,
  output logic [WIDTH-1:0]      s_data_out,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  m_valid_q, m_valid_d;
  logic [WIDTH-1:0]      m_data_q, m_data_d;
  logic                  full_q, full_d;
  logic [WIDTH-1:0]      buf_q, buf_d;
  logic                  s_ready_q;
  logic [WIDTH-1:0]      s_data_q, s_data_d;

  logic m_take, m_load, s_take;

  assign m_ready    = ~full_q;
  assign m_valid    = m_valid_q;
  assign m_data_out = m_data_q;
  assign s_valid    = full_q | m_valid_q;
  assign s_data_in  = full_q ? buf_q : m_data_q;
  assign s_ready    = s_ready_q;
  assign s_data_out = s_data_q;
  assign addr       = addr_q;

  assign m_take = m_valid_q & m_ready;
  assign m_load = ~m_valid_q | m_ready;
  assign s_take = s_valid & s_ready_q;

  always_comb begin
    addr_d    = addr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    full_d    = full_q;
    buf_d     = buf_q;
    s_data_d  = s_data_q;

    // Master: a held word never changes until it has been taken.
    if (m_load) begin
      if (valid_en) begin
        m_data_d  = m_data_in;
        m_valid_d = 1'b1;
        addr_d    = addr_q + ADDR_WIDTH'(1);
      end else begin
        m_valid_d = 1'b0;
      end
    end

    // Buffer: only an empty buffer captures, so the slave always sees the older word first.
    if (full_q) begin
      if (s_ready_q) full_d = 1'b0;
    end else if (m_take && !s_ready_q) begin
      buf_d  = m_data_q;
      full_d = 1'b1;
    end

    if (s_take) s_data_d = s_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      full_q    <= 1'b0;
      buf_q     <= '0;
      s_ready_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      addr_q    <= addr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      full_q    <= full_d;
      buf_q     <= buf_d;
      s_ready_q <= ready_en;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: tb/tb_top_handshakes.sv
// Bench for top_handshakes: queue-based transfer model checked every cycle, an in-order
// scoreboard on slave takes, and hand-computed literals at the end of each directed phase.
module tb_top_handshakes;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_en = 1'b0;
  logic       ready_en = 1'b0;
  logic       m_valid, m_ready, s_valid, s_ready;
  logic [7:0] m_data_in, m_data_out, s_data_in, s_data_out, addr;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  top_handshakes #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .valid_en(valid_en), .ready_en(ready_en),
    .m_valid(m_valid), .m_ready(m_ready), .s_valid(s_valid), .s_ready(s_ready),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .s_data_in(s_data_in),
    .s_data_out(s_data_out), .addr(addr)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  assign m_data_in = mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words in flight form an ordered queue; nbuf of them (front) sit in the skid buffer,
  // the rest is the master's held word.
  int q[$];
  int nbuf = 0, m_word = 0, maddr = 0, last = 0;
  bit sr = 0, started = 0;
  bit mv, mr, st, ml;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      nbuf = 0; m_word = 0; maddr = 0; last = 0; sr = 0; started = 1;
    end else if (started) begin
      mr = (nbuf == 0);
      mv = (q.size() > nbuf);
      st = (q.size() > 0) && sr;
      ml = !mv || mr;
      if (st) begin
        last = q.pop_front();
        nbuf = 0;
      end else if (mv && mr) begin
        nbuf = 1;
      end
      if (ml && valid_en) begin
        m_word = int'(mem[maddr]);
        q.push_back(m_word);
        maddr = (maddr + 1) % 256;
      end
      sr = ready_en;
    end
  end

  int sb_next = 0;

  always @(negedge clk) begin
    if (started) begin
      check("m_valid", 32'(m_valid), 32'(q.size() > nbuf));
      check("m_ready", 32'(m_ready), 32'(nbuf == 0));
      check("s_valid", 32'(s_valid), 32'(q.size() > 0));
      check("s_ready", 32'(s_ready), 32'(sr));
      check("m_data_out", 32'(m_data_out), 32'(m_word));
      check("s_data_in", 32'(s_data_in), 32'((q.size() > 0) ? q[0] : m_word));
      check("s_data_out", 32'(s_data_out), 32'(last));
      check("addr", 32'(addr), 32'(maddr));
      if (rst) sb_next = 0;
      else if (s_valid && s_ready) begin
        check("sb_order", 32'(s_data_in), 32'(sb_next));
        sb_next = (sb_next + 1) % 256;
      end
    end
  end

  task automatic run(input int n, input logic ve, input logic re);
    valid_en = ve;
    ready_en = re;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    check("lit_rst_m_ready", 32'(m_ready), 32'd1);
    check("lit_rst_s_valid", 32'(s_valid), 32'd0);
    check("lit_rst_addr", 32'(addr), 32'd0);
    rst = 1'b0;

    // Streaming
    run(10, 1'b1, 1'b1);
    check("lit_stream_out", 32'(s_data_out), 32'd8);
    check("lit_stream_addr", 32'(addr), 32'd10);

    // Slave stall: one word captured, addr frozen
    run(4, 1'b1, 1'b0);
    check("lit_stall_addr", 32'(addr), 32'd12);
    check("lit_stall_m_ready", 32'(m_ready), 32'd0);
    check("lit_stall_out", 32'(s_data_out), 32'd9);
    check("lit_stall_buf", 32'(s_data_in), 32'd10);
    run(6, 1'b1, 1'b1);
    check("lit_resume_out", 32'(s_data_out), 32'd14);
    check("lit_resume_addr", 32'(addr), 32'd16);

    // Master idle
    run(5, 1'b0, 1'b1);
    check("lit_idle_s_valid", 32'(s_valid), 32'd0);
    check("lit_idle_out", 32'(s_data_out), 32'd15);
    check("lit_idle_addr", 32'(addr), 32'd16);

    // Stall then idle
    run(3, 1'b1, 1'b1);
    run(4, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1);
    check("lit_si_s_valid", 32'(s_valid), 32'd0);
    check("lit_si_out", 32'(s_data_out), 32'd18);
    check("lit_si_addr", 32'(addr), 32'd19);

    // Wrap past 255
    run(270, 1'b1, 1'b1);
    check("lit_wrap_out", 32'(s_data_out), 32'd31);
    check("lit_wrap_addr", 32'(addr), 32'd33);

    // Reset with the buffer full
    run(4, 1'b1, 1'b0);
    check("lit_pre_rst_m_ready", 32'(m_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("lit_rst2_m_valid", 32'(m_valid), 32'd0);
    check("lit_rst2_m_ready", 32'(m_ready), 32'd1);
    check("lit_rst2_s_valid", 32'(s_valid), 32'd0);
    check("lit_rst2_s_ready", 32'(s_ready), 32'd0);
    check("lit_rst2_s_data_in", 32'(s_data_in), 32'd0);
    check("lit_rst2_s_data_out", 32'(s_data_out), 32'd0);
    check("lit_rst2_addr", 32'(addr), 32'd0);
    rst = 1'b0;

    // Random handshake pressure
    for (int i = 0; i < 400; i++) run(1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    run(12, 1'b0, 1'b1);
    check("lit_drain_s_valid", 32'(s_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
